// File: rtl/qos_ctrl_fsm_pkg.sv
// Shared definitions for the QoS control FSM and its threshold register bank.
package qos_pkg;

    // Default number of monitored FIFOs (VC0, VC1, MF, D0, D1)
    localparam int unsigned NFIFO_DEF = 5;

    // Threshold field widths
    localparam int unsigned MF_W = 4;
    localparam int unsigned VC_W = 16;
    localparam int unsigned D_W  = 4;

    // Packed configuration bus widths
    localparam int unsigned VCS_W = 2 * VC_W;
    localparam int unsigned DS_W  = 2 * D_W;

    // Controller states
    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } qos_state_t;

endpackage

// File: rtl/qos_umbral_regs.sv
// Threshold register bank: captures the configuration thresholds while load is
// high and holds them otherwise.
module qos_umbral_regs
    import qos_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [MF_W-1:0] mf_in,
    input  logic [VCS_W-1:0] vc_in,
    input  logic [DS_W-1:0] d_in,
    output logic [MF_W-1:0] mf,
    output logic [VC_W-1:0] v0,
    output logic [VC_W-1:0] v1,
    output logic [D_W-1:0]  d0,
    output logic [D_W-1:0]  d1
);

    // Load every edge while enabled; cleared asynchronously on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mf <= '0;
            v0 <= '0;
            v1 <= '0;
            d0 <= '0;
            d1 <= '0;
        end else if (load) begin
            mf <= mf_in;
            v0 <= vc_in[VC_W-1:0];
            v1 <= vc_in[VCS_W-1:VC_W];
            d0 <= d_in[D_W-1:0];
            d1 <= d_in[DS_W-1:D_W];
        end
    end

endmodule

// File: rtl/qos_ctrl_fsm.sv
// Main QoS control state machine: sequences reset/init/idle/active/error,
// latches thresholds during INIT and keeps a sticky record of FIFO errors.
module qos_ctrl_fsm
    import qos_pkg::*;
#(
    parameter int unsigned NFIFO = NFIFO_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic [MF_W-1:0]  UmbralesMFs,
    input  logic [VCS_W-1:0] UmbralesVCs,
    input  logic [DS_W-1:0]  UmbralesDs,
    input  logic [NFIFO-1:0] FIFO_EMPTIES,
    input  logic [NFIFO-1:0] FIFO_ERRORS,
    output logic             error_out,
    output logic             active_out,
    output logic             idle_out,
    output logic [MF_W-1:0]  UmbralMF,
    output logic [VC_W-1:0]  UmbralV0,
    output logic [VC_W-1:0]  UmbralV1,
    output logic [D_W-1:0]   UmbralD0,
    output logic [D_W-1:0]   UmbralD1,
    output logic [NFIFO-1:0] error_full
);

    qos_state_t state;
    logic       load;

    // Thresholds are only writable while sitting in INIT
    always_comb begin
        load = (state == ST_INIT);
    end

    qos_umbral_regs u_umbral_regs (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .mf_in (UmbralesMFs),
        .vc_in (UmbralesVCs),
        .d_in  (UmbralesDs),
        .mf    (UmbralMF),
        .v0    (UmbralV0),
        .v1    (UmbralV1),
        .d0    (UmbralD0),
        .d1    (UmbralD1)
    );

    // State transitions with registered state flags and the sticky error latch;
    // flags are set alongside the next state so they never depend on inputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_RESET;
            error_out  <= 1'b0;
            active_out <= 1'b0;
            idle_out   <= 1'b0;
            error_full <= '0;
        end else begin
            case (state)
                ST_RESET: begin
                    state      <= ST_INIT;
                    error_out  <= 1'b0;
                    active_out <= 1'b0;
                    idle_out   <= 1'b0;
                end
                ST_INIT: begin
                    if (init) begin
                        state      <= ST_INIT;
                        error_out  <= 1'b0;
                        active_out <= 1'b0;
                        idle_out   <= 1'b0;
                    end else begin
                        state      <= ST_IDLE;
                        error_out  <= 1'b0;
                        active_out <= 1'b0;
                        idle_out   <= 1'b1;
                    end
                end
                ST_IDLE, ST_ACTIVE: begin
                    error_full <= error_full | FIFO_ERRORS;
                    if (|FIFO_ERRORS) begin
                        state      <= ST_ERROR;
                        error_out  <= 1'b1;
                        active_out <= 1'b0;
                        idle_out   <= 1'b0;
                    end else if (init) begin
                        state      <= ST_INIT;
                        error_out  <= 1'b0;
                        active_out <= 1'b0;
                        idle_out   <= 1'b0;
                    end else if (&FIFO_EMPTIES) begin
                        state      <= ST_IDLE;
                        error_out  <= 1'b0;
                        active_out <= 1'b0;
                        idle_out   <= 1'b1;
                    end else begin
                        state      <= ST_ACTIVE;
                        error_out  <= 1'b0;
                        active_out <= 1'b1;
                        idle_out   <= 1'b0;
                    end
                end
                ST_ERROR: begin
                    state      <= ST_ERROR;
                    error_out  <= 1'b1;
                    active_out <= 1'b0;
                    idle_out   <= 1'b0;
                end
                default: begin
                    state      <= ST_RESET;
                    error_out  <= 1'b0;
                    active_out <= 1'b0;
                    idle_out   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qos_ctrl_fsm.sv
// Randomized self-checking bench for qos_ctrl_fsm against a behavioural model.
module tb_qos_ctrl_fsm;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        init = 1'b0;
    logic [3:0]  UmbralesMFs = '0;
    logic [31:0] UmbralesVCs = '0;
    logic [7:0]  UmbralesDs = '0;
    logic [4:0]  FIFO_EMPTIES = '1;
    logic [4:0]  FIFO_ERRORS = '0;
    logic        error_out, active_out, idle_out;
    logic [3:0]  UmbralMF, UmbralD0, UmbralD1;
    logic [15:0] UmbralV0, UmbralV1;
    logic [4:0]  error_full;

    int checks = 0;
    int errors = 0;

    // Model: phase 0=reset, 1=init, 2=running (idle or active), 3=error
    int          m_phase;
    bit          m_idle;
    logic [3:0]  m_mf, m_d0, m_d1;
    logic [15:0] m_v0, m_v1;
    logic [4:0]  m_ef;

    always #5 clk = ~clk;

    qos_ctrl_fsm #(.NFIFO(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .init         (init),
        .UmbralesMFs  (UmbralesMFs),
        .UmbralesVCs  (UmbralesVCs),
        .UmbralesDs   (UmbralesDs),
        .FIFO_EMPTIES (FIFO_EMPTIES),
        .FIFO_ERRORS  (FIFO_ERRORS),
        .error_out    (error_out),
        .active_out   (active_out),
        .idle_out     (idle_out),
        .UmbralMF     (UmbralMF),
        .UmbralV0     (UmbralV0),
        .UmbralV1     (UmbralV1),
        .UmbralD0     (UmbralD0),
        .UmbralD1     (UmbralD1),
        .error_full   (error_full)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_phase = 0;
        m_idle  = 1'b0;
        m_mf = '0; m_d0 = '0; m_d1 = '0;
        m_v0 = '0; m_v1 = '0;
        m_ef = '0;
    endtask

    // Advance the model by one rising edge using the currently driven inputs
    task automatic model_step();
        if (reset) begin
            model_clear();
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            m_mf = UmbralesMFs;
            m_v0 = UmbralesVCs[15:0];
            m_v1 = UmbralesVCs[31:16];
            m_d0 = UmbralesDs[3:0];
            m_d1 = UmbralesDs[7:4];
            if (!init) begin
                m_phase = 2;
                m_idle  = 1'b1;
            end
        end else if (m_phase == 2) begin
            if (FIFO_ERRORS != 0) begin
                m_ef    = m_ef | FIFO_ERRORS;
                m_phase = 3;
            end else if (init) begin
                m_phase = 1;
            end else begin
                m_idle = (FIFO_EMPTIES == 5'h1f);
            end
        end
    endtask

    task automatic compare_all(input string tag);
        logic [2:0] exp_flags;
        exp_flags = {m_phase == 3, (m_phase == 2) && !m_idle, (m_phase == 2) && m_idle};
        check_val({tag, ".flags"}, {61'd0, error_out, active_out, idle_out}, {61'd0, exp_flags});
        check_val({tag, ".thr"}, {20'd0, UmbralMF, UmbralV0, UmbralV1, UmbralD0, UmbralD1},
                  {20'd0, m_mf, m_v0, m_v1, m_d0, m_d1});
        check_val({tag, ".efull"}, {59'd0, error_full}, {59'd0, m_ef});
    endtask

    // One clock: drive inputs at negedge, check after the following rising edge
    task automatic cycle(input logic r, input logic i, input logic [3:0] mf, input logic [31:0] vc,
                         input logic [7:0] d, input logic [4:0] emp, input logic [4:0] err,
                         input string tag);
        @(negedge clk);
        reset = r; init = i; UmbralesMFs = mf; UmbralesVCs = vc; UmbralesDs = d;
        FIFO_EMPTIES = emp; FIFO_ERRORS = err;
        if (r) begin
            model_clear();
            #1 compare_all({tag, ".async"});
        end
        @(posedge clk);
        model_step();
        #1 compare_all(tag);
    endtask

    initial begin
        model_clear();

        // Power-on reset, then the documented bring-up sequence
        cycle(1, 0, 4'hf, 32'hbcbcaaff, 8'hfa, 5'h1f, 5'h00, "por");
        cycle(0, 0, 4'hf, 32'hbcbcaaff, 8'hfa, 5'h1f, 5'h00, "rst_to_init");
        check_val("init_flags", {error_out, active_out, idle_out}, 3'b000);
        cycle(0, 0, 4'hf, 32'hbcbcaaff, 8'hfa, 5'h1f, 5'h00, "init_to_idle");
        check_val("idle_const", idle_out, 1'b1);
        check_val("v0_const", UmbralV0, 16'haaff);
        check_val("v1_const", UmbralV1, 16'hbcbc);
        check_val("d0_const", UmbralD0, 4'ha);
        check_val("d1_const", UmbralD1, 4'hf);
        check_val("mf_const", UmbralMF, 4'hf);

        cycle(0, 0, 4'hf, 32'hbcbcaaff, 8'hfa, 5'b11110, 5'h00, "to_active");
        check_val("active_const", active_out, 1'b1);
        cycle(0, 0, 4'hf, 32'hbcbcaaff, 8'hfa, 5'h1f, 5'h00, "back_idle");
        cycle(0, 0, 4'h9, 32'hcbcbaabb, 8'hca, 5'b10101, 5'h00, "thr_ignored");
        check_val("thr_hold_const", UmbralV0, 16'haaff);
        cycle(0, 0, 4'h9, 32'hcbcbaabb, 8'hca, 5'b10101, 5'b01001, "to_error");
        check_val("err_const", error_out, 1'b1);
        check_val("efull_const", error_full, 5'b01001);
        cycle(0, 1, 4'h3, 32'h12345678, 8'h11, 5'h1f, 5'h00, "err_hold1");
        cycle(0, 0, 4'h3, 32'h12345678, 8'h11, 5'h03, 5'b10000, "err_hold2");
        check_val("efull_hold_const", error_full, 5'b01001);

        // Re-initialisation from IDLE
        cycle(1, 0, 4'hf, 32'hbcbcaaff, 8'hfa, 5'h1f, 5'h00, "rst2");
        cycle(0, 0, 4'hf, 32'hbcbcaaff, 8'hfa, 5'h1f, 5'h00, "rst2_init");
        cycle(0, 0, 4'hf, 32'hbcbcaaff, 8'hfa, 5'h1f, 5'h00, "rst2_idle");
        for (int k = 0; k < 3; k++)
            cycle(0, 1, 4'h9, 32'hcbcbaabb, 8'hca, 5'h1f, 5'h00, "reinit");
        check_val("reinit_v0_const", UmbralV0, 16'haabb);
        check_val("reinit_v1_const", UmbralV1, 16'hcbcb);
        cycle(0, 0, 4'h9, 32'hcbcbaabb, 8'hca, 5'h1f, 5'b00110, "init_err_ignored");
        check_val("init_err_efull", error_full, 5'b00000);

        // Error and init together: error wins
        cycle(0, 1, 4'h1, 32'h0, 8'h0, 5'h00, 5'b00010, "err_beats_init");

        // Asynchronous reset while in ERROR, mid-cycle
        @(posedge clk);
        #2 reset = 1'b1;
        model_clear();
        #1 compare_all("async_rst");
        check_val("async_rst_const", {error_out, error_full}, 6'd0);
        cycle(1, 0, 4'h5, 32'h0f0f1234, 8'h76, 5'h1f, 5'h00, "rst3");
        cycle(0, 0, 4'h5, 32'h0f0f1234, 8'h76, 5'h1f, 5'h00, "rst3_init");
        cycle(0, 0, 4'h5, 32'h0f0f1234, 8'h76, 5'h1f, 5'h00, "rst3_idle");

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic       r, i;
            logic [4:0] emp, err;
            r   = ($urandom_range(0, 59) == 0);
            i   = ($urandom_range(0, 9) == 0);
            emp = ($urandom_range(0, 1) == 0) ? 5'h1f : 5'($urandom);
            err = ($urandom_range(0, 29) == 0) ? 5'($urandom) : 5'h00;
            cycle(r, i, 4'($urandom), 32'($urandom), 8'($urandom), emp, err, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/qos_ctrl_fsm.md
# qos_ctrl_fsm

Main control state machine for the PCIe QoS datapath: it consumes the configuration and FIFO status stimulus (init, threshold buses, FIFO empty/error flags) and produces the state indications and the latched per-FIFO thresholds used by the VC, MF and D FIFOs. It sits between the configuration source and the FIFO bank. Thresholds are captured only during initialisation, and FIFO errors are made sticky until reset.

## Interface
- `NFIFO`, 5, number of monitored FIFOs (width of empty/error vectors)
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `init`  in  1  request (re)initialisation / threshold load
- `UmbralesMFs`  in  4  main-FIFO threshold
- `UmbralesVCs`  in  32  VC thresholds, [15:0]=VC0, [31:16]=VC1
- `UmbralesDs`  in  8  D thresholds, [3:0]=D0, [7:4]=D1
- `FIFO_EMPTIES`  in  NFIFO  1 = FIFO i empty
- `FIFO_ERRORS`  in  NFIFO  1 = FIFO i overflow/underflow error
- `error_out`  out  1  state == ERROR
- `active_out`  out  1  state == ACTIVE
- `idle_out`  out  1  state == IDLE
- `UmbralMF`  out  4  latched MF threshold
- `UmbralV0` / `UmbralV1`  out  16  latched VC0/VC1 thresholds
- `UmbralD0` / `UmbralD1`  out  4  latched D0/D1 thresholds
- `error_full`  out  NFIFO  sticky OR of FIFO_ERRORS seen in IDLE/ACTIVE

## Operation
- States: RESET, INIT, IDLE, ACTIVE, ERROR.
- While `reset`=1: state RESET, all outputs and threshold registers 0, error_full 0.
- RESET → INIT unconditionally on the first edge after reset deasserts.
- INIT: thresholds loaded every edge (`UmbralMF`←UmbralesMFs, V0←VCs[15:0], V1←VCs[31:16], D0←Ds[3:0], D1←Ds[7:4]). Stay while `init`=1; `init`=0 → IDLE.
- IDLE / ACTIVE next-state, priority high→low:
  - any FIFO_ERRORS bit → ERROR; error_full ← error_full | FIFO_ERRORS
  - `init`=1 → INIT
  - FIFO_EMPTIES all ones → IDLE
  - otherwise → ACTIVE
- ERROR: absorbing until reset. Ignores init, FIFO_EMPTIES, FIFO_ERRORS and threshold inputs; error_full holds.
- Thresholds hold in every state except INIT; input changes outside INIT have no effect.
- Exactly one of idle_out/active_out/error_out is 1 in IDLE/ACTIVE/ERROR; all three are 0 in RESET and INIT.

## Timing
- State, threshold and error_full registers update on the rising edge of clk. Outputs are a direct decode of registers, with no combinational path from inputs to outputs.
- Latency: an input condition sampled at edge N is visible on outputs after edge N.
- After reset release: edge 1 → INIT (thresholds captured at edge 2). With init=0, IDLE/ACTIVE follows at edge 2.
- Reset mid-operation, including in ERROR: outputs clear asynchronously and immediately. The full sequence restarts from RESET.
- Simultaneous error and init in IDLE/ACTIVE: ERROR wins. Init is not honoured.
- Error bits asserted in INIT are not recorded. Errors are evaluated only in IDLE/ACTIVE.

## Structure
- Shared package `qos_pkg`:
  - state encoding constants ST_RESET..ST_ERROR (3-bit)
  - threshold widths (MF=4, VC=16, D=4)
  - NFIFO default
- Natural sub-module: `qos_umbral_regs`, the threshold register bank with a load enable driven from `state==INIT`. The FSM and error_full latch stay in the top module.

## Test plan
- Reset sequence, UmbralesVCs=32'hbcbcaaff, UmbralesDs=8'hfa, UmbralesMFs=4'hf, FIFO_EMPTIES=5'h1f, init=0 → INIT after 1 edge, then idle_out=1. Required outputs: UmbralV0=16'haaff, V1=16'hbcbc, D0=4'ha, D1=4'hf, MF=4'hf.
- From IDLE, FIFO_EMPTIES=5'b11110 → active_out=1 next edge. Back to 5'h1f → idle_out=1 next edge.
- In ACTIVE, change thresholds to 32'hcbcbaabb / 8'hca / 4'h9 with init=0 → latched thresholds unchanged.
- FIFO_ERRORS=5'b01001 in ACTIVE → error_out=1, error_full=5'b01001. Later FIFO_ERRORS=0 and FIFO_EMPTIES changes → still ERROR, error_full unchanged.
- init=1 for 3 cycles from IDLE with new thresholds 32'hcbcbaabb → INIT (all state outputs 0), new values latched. init=0 → IDLE/ACTIVE.
- Assert reset asynchronously in ERROR mid-cycle → all outputs 0 before the next edge. Release → RESET→INIT→IDLE sequence repeats.
